jstk_poll_ctrl: RTL and testbench

- Periodic sequencer for the PmodJSTK joystick.
- Generates an internal poll tick every TICK_MAX+1 cycles. On each tick it runs one 5-byte SPI transaction through an external byte-level SPI engine using a start/done handshake, with the required slave-select setup and inter-byte gaps.
- Assembles the returned bytes into X/Y position and button outputs, then pulses VALID.
- Sits between the SPI byte engine and the car's control logic.

---
 rtl/jstk_poll_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_jstk_poll_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jstk_poll_ctrl
// Purpose  : Periodic PmodJSTK poller; runs a 5-byte SPI exchange per tick
//            through a byte-level SPI engine and publishes X/Y/BTN.
// Revision : 1.0 - initial release
// ============================================================================
module jstk_poll_ctrl #(
    parameter int TICK_MAX = 4999999,
    parameter int SS_SETUP = 1499,
    parameter int BYTE_GAP = 999
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [1:0] LED,
    output logic       SPI_START,
    output logic [7:0] SPI_TXD,
    input  logic       SPI_DONE,
    input  logic [7:0] SPI_RXD,
    output logic       SS,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic [2:0] BTN,
    output logic       VALID,
    output logic       BUSY
);

    localparam int CW      = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int DLY_MAX = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int DW      = (DLY_MAX > 0) ? $clog2(DLY_MAX + 1) : 1;

    localparam logic [CW-1:0] C_TICK_MAX = CW'(TICK_MAX);
    localparam logic [DW-1:0] C_SS_SETUP = DW'(SS_SETUP);
    localparam logic [DW-1:0] C_BYTE_GAP = DW'(BYTE_GAP);
    localparam logic [2:0]    C_LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [2:0]      idx_q, idx_d;
    logic [1:0]      led_q, led_d;
    logic            ss_q, ss_d;
    logic [7:0]      txd_q, txd_d;
    logic [7:0]      b0_q, b0_d;
    logic [1:0]      b1_q, b1_d;
    logic [7:0]      b2_q, b2_d;
    logic [1:0]      b3_q, b3_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic [2:0]      btn_q, btn_d;
    logic            valid_q, valid_d;
    logic            tick;

    assign tick = EN && (cnt_q == C_TICK_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        dly_d   = dly_q;
        idx_d   = idx_q;
        led_d   = led_q;
        ss_d    = ss_q;
        txd_d   = txd_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        b3_d    = b3_q;
        x_d     = x_q;
        y_d     = y_q;
        btn_d   = btn_q;
        valid_d = 1'b0;

        if (EN && (cnt_q != C_TICK_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    led_d   = LED;
                    ss_d    = 1'b0;
                    idx_d   = '0;
                    dly_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (dly_q == C_SS_SETUP) begin
                    txd_d   = {6'b100000, led_q};
                    state_d = S_XFER;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_XFER: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (SPI_DONE) begin
                    case (idx_q)
                        3'd0:    b0_d = SPI_RXD;
                        3'd1:    b1_d = SPI_RXD[1:0];
                        3'd2:    b2_d = SPI_RXD;
                        3'd3:    b3_d = SPI_RXD[1:0];
                        default: ;
                    endcase
                    // Final byte: publish all fields together on this edge
                    if (idx_q == C_LAST_IDX) begin
                        x_d     = {b1_q, b0_q};
                        y_d     = {b3_q, b2_q};
                        btn_d   = SPI_RXD[2:0];
                        valid_d = 1'b1;
                        ss_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        dly_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (dly_q == C_BYTE_GAP) begin
                    txd_d   = 8'h00;
                    state_d = S_XFER;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            idx_q   <= '0;
            led_q   <= '0;
            ss_q    <= 1'b1;
            txd_q   <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            b3_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            btn_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            ss_q    <= ss_d;
            txd_q   <= txd_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            b3_q    <= b3_d;
            x_q     <= x_d;
            y_q     <= y_d;
            btn_q   <= btn_d;
            valid_q <= valid_d;
        end
    end

    assign SPI_START = (state_q == S_XFER);
    assign SPI_TXD   = txd_q;
    assign SS        = ss_q;
    assign X         = x_q;
    assign Y         = y_q;
    assign BTN       = btn_q;
    assign VALID     = valid_q;
    assign BUSY      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jstk_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jstk_poll_ctrl
// Purpose  : Directed self-checking bench for jstk_poll_ctrl with a simple
//            SPI byte-engine model (DONE five cycles after START).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jstk_poll_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN  = 1'b0;
    logic [1:0] LED = 2'b00;
    logic       SPI_START;
    logic [7:0] SPI_TXD;
    logic       SPI_DONE;
    logic [7:0] SPI_RXD;
    logic       SS;
    logic [9:0] X;
    logic [9:0] Y;
    logic [2:0] BTN;
    logic       VALID;
    logic       BUSY;

    logic       model_done = 1'b0;
    logic [7:0] model_rxd  = 8'h00;
    logic       extra_done = 1'b0;
    logic [7:0] rx_bytes [5];

    int vectors    = 0;
    int miscompares = 0;

    // Event log, written only by the monitor
    int         cyc = 0;
    logic       prev_ss = 1'b1;
    int         n_st = 0, n_dn = 0, n_valid = 0, n_fall = 0, n_rise = 0, ss_bad = 0;
    int         st_cyc [256];
    logic [7:0] st_txd [256];
    int         dn_cyc [256];
    int         v_cyc  [256];
    int         fall_cyc [64];
    int         rise_cyc [64];

    assign SPI_DONE = model_done | extra_done;
    assign SPI_RXD  = model_rxd;

    jstk_poll_ctrl #(
        .TICK_MAX (99),
        .SS_SETUP (3),
        .BYTE_GAP (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .LED       (LED),
        .SPI_START (SPI_START),
        .SPI_TXD   (SPI_TXD),
        .SPI_DONE  (SPI_DONE),
        .SPI_RXD   (SPI_RXD),
        .SS        (SS),
        .X         (X),
        .Y         (Y),
        .BTN       (BTN),
        .VALID     (VALID),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    // SPI byte engine: DONE is high in the fifth cycle after the START cycle
    initial begin : spi_model
        int cd;
        int mi;
        cd = 0;
        mi = 0;
        forever begin
            @(posedge CLK);
            #2;
            model_done = 1'b0;
            if (!RST) begin
                cd = 0;
                mi = 0;
            end else begin
                if (cd != 0) begin
                    cd = cd - 1;
                    if (cd == 0) begin
                        model_done = 1'b1;
                        model_rxd  = rx_bytes[mi];
                        mi = (mi == 4) ? 0 : mi + 1;
                    end
                end
                if (SPI_START) cd = 5;
            end
        end
    end

    always @(negedge CLK) begin
        cyc     <= cyc + 1;
        prev_ss <= SS;
        if (SPI_START) begin
            st_cyc[n_st] <= cyc;
            st_txd[n_st] <= SPI_TXD;
            n_st <= n_st + 1;
        end
        if (model_done) begin
            dn_cyc[n_dn] <= cyc;
            n_dn <= n_dn + 1;
        end
        if (VALID) begin
            v_cyc[n_valid] <= cyc;
            n_valid <= n_valid + 1;
        end
        if (prev_ss === 1'b1 && SS === 1'b0) begin
            fall_cyc[n_fall] <= cyc;
            n_fall <= n_fall + 1;
        end
        if (prev_ss === 1'b0 && SS === 1'b1) begin
            rise_cyc[n_rise] <= cyc;
            n_rise <= n_rise + 1;
        end
        if (SS !== ~BUSY) ss_bad <= ss_bad + 1;
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic set_rx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input logic [7:0] e);
        rx_bytes[0] = a; rx_bytes[1] = b; rx_bytes[2] = c; rx_bytes[3] = d; rx_bytes[4] = e;
    endtask

    function automatic int ev(input int sel);
        case (sel)
            0:       return n_valid;
            1:       return n_fall;
            2:       return n_dn;
            default: return n_st;
        endcase
    endfunction

    // sel: 0=VALID, 1=SS fall, 2=model DONE, 3=START
    task automatic wait_for(input int sel, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ev(sel) >= target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ev(sel) >= target) ok = 1'b1;
    endtask

    task automatic pulse_done();
        extra_done = 1'b1;
        step();
        extra_done = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) step();
        vectors++; if (SS !== 1'b1)      begin miscompares++; $display("FAIL reset_ss: got %b want 1", SS); end
        vectors++; if (VALID !== 1'b0)   begin miscompares++; $display("FAIL reset_valid: got %b want 0", VALID); end
        vectors++; if (BUSY !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        vectors++; if (SPI_START !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b want 0", SPI_START); end
        vectors++; if (SPI_TXD !== 8'h00) begin miscompares++; $display("FAIL reset_txd: got %h want 00", SPI_TXD); end
        vectors++; if (X !== 10'h000)    begin miscompares++; $display("FAIL reset_x: got %h want 000", X); end
        vectors++; if (Y !== 10'h000)    begin miscompares++; $display("FAIL reset_y: got %h want 000", Y); end
        vectors++; if (BTN !== 3'b000)   begin miscompares++; $display("FAIL reset_btn: got %b want 000", BTN); end
        RST = 1'b1;
        step();
    endtask

    task automatic test_normal();
        int bs, bd, bf, br, bv, e_cyc;
        bit ok;
        logic [7:0] exp_txd;
        set_rx(8'h34, 8'h02, 8'hC8, 8'h01, 8'h05);
        LED = 2'b10;
        bs = n_st; bd = n_dn; bf = n_fall; br = n_rise; bv = n_valid;
        EN = 1'b1;
        e_cyc = cyc - 1;
        wait_for(0, bv + 1, 250, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL normal_timeout: no VALID within 250 cycles"); end
        vectors++; if (X !== 10'h234)  begin miscompares++; $display("FAIL normal_x: got %h want 234", X); end
        vectors++; if (Y !== 10'h1C8)  begin miscompares++; $display("FAIL normal_y: got %h want 1c8", Y); end
        vectors++; if (BTN !== 3'b101) begin miscompares++; $display("FAIL normal_btn: got %b want 101", BTN); end
        step(); step();
        vectors++; if (n_valid - bv !== 1) begin miscompares++; $display("FAIL normal_valid_cnt: got %0d want 1", n_valid - bv); end
        vectors++; if (n_st - bs !== 5) begin miscompares++; $display("FAIL normal_starts: got %0d want 5", n_st - bs); end
        for (int k = 0; k < 5; k++) begin
            exp_txd = (k == 0) ? 8'h82 : 8'h00;
            vectors++;
            if (st_txd[bs + k] !== exp_txd) begin
                miscompares++; $display("FAIL normal_txd%0d: got %h want %h", k, st_txd[bs + k], exp_txd);
            end
        end
        vectors++; if (fall_cyc[bf] - e_cyc !== 100) begin miscompares++; $display("FAIL normal_tick_period: got %0d want 100", fall_cyc[bf] - e_cyc); end
        vectors++; if (st_cyc[bs] - fall_cyc[bf] !== 4) begin miscompares++; $display("FAIL normal_setup: got %0d want 4", st_cyc[bs] - fall_cyc[bf]); end
        for (int k = 1; k < 5; k++) begin
            vectors++;
            if (st_cyc[bs + k] - dn_cyc[bd + k - 1] !== 4) begin
                miscompares++; $display("FAIL normal_gap%0d: got %0d want 4", k, st_cyc[bs + k] - dn_cyc[bd + k - 1]);
            end
        end
        vectors++; if (rise_cyc[br] - dn_cyc[bd + 4] !== 1) begin miscompares++; $display("FAIL normal_ss_rise: got %0d want 1", rise_cyc[br] - dn_cyc[bd + 4]); end
        vectors++; if (v_cyc[bv] - dn_cyc[bd + 4] !== 1) begin miscompares++; $display("FAIL normal_valid_time: got %0d want 1", v_cyc[bv] - dn_cyc[bd + 4]); end
        vectors++; if (ss_bad !== 0) begin miscompares++; $display("FAIL normal_ss_vs_busy: got %0d want 0", ss_bad); end
    endtask

    task automatic test_led_change();
        int bs, bf, bv;
        bit ok;
        set_rx(8'hFF, 8'h03, 8'h00, 8'h02, 8'h02);
        bs = n_st; bf = n_fall; bv = n_valid;
        wait_for(1, bf + 1, 150, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL led_timeout_ss: no SS fall within 150 cycles"); end
        LED = 2'b01;
        wait_for(0, bv + 1, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL led_timeout_valid: no VALID within 100 cycles"); end
        vectors++; if (st_txd[bs] !== 8'h82) begin miscompares++; $display("FAIL led_txd0: got %h want 82", st_txd[bs]); end
        vectors++; if (X !== 10'h3FF)  begin miscompares++; $display("FAIL led_x: got %h want 3ff", X); end
        vectors++; if (Y !== 10'h200)  begin miscompares++; $display("FAIL led_y: got %h want 200", Y); end
        vectors++; if (BTN !== 3'b010) begin miscompares++; $display("FAIL led_btn: got %b want 010", BTN); end
        vectors++; if (fall_cyc[bf] - fall_cyc[bf - 1] !== 100) begin miscompares++; $display("FAIL led_period: got %0d want 100", fall_cyc[bf] - fall_cyc[bf - 1]); end
    endtask

    task automatic test_stray_done();
        int bs, bd, bf, bv;
        bit ok;
        set_rx(8'h9A, 8'h00, 8'h3C, 8'h03, 8'h06);
        bs = n_st; bd = n_dn; bf = n_fall; bv = n_valid;
        step();
        pulse_done();
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL stray_idle_busy: got %b want 0", BUSY); end
        vectors++; if (SS !== 1'b1)   begin miscompares++; $display("FAIL stray_idle_ss: got %b want 1", SS); end
        wait_for(1, bf + 1, 150, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stray_timeout_ss: no SS fall within 150 cycles"); end
        wait_for(2, bd + 1, 30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stray_timeout_done: no first DONE within 30 cycles"); end
        step();
        pulse_done();
        wait_for(0, bv + 1, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stray_timeout_valid: no VALID within 100 cycles"); end
        vectors++; if (n_st - bs !== 5) begin miscompares++; $display("FAIL stray_starts: got %0d want 5", n_st - bs); end
        vectors++; if (st_txd[bs] !== 8'h81) begin miscompares++; $display("FAIL stray_txd0: got %h want 81", st_txd[bs]); end
        vectors++; if (st_cyc[bs + 1] - dn_cyc[bd] !== 4) begin miscompares++; $display("FAIL stray_gap: got %0d want 4", st_cyc[bs + 1] - dn_cyc[bd]); end
        vectors++; if (X !== 10'h09A)  begin miscompares++; $display("FAIL stray_x: got %h want 09a", X); end
        vectors++; if (Y !== 10'h33C)  begin miscompares++; $display("FAIL stray_y: got %h want 33c", Y); end
        vectors++; if (BTN !== 3'b110) begin miscompares++; $display("FAIL stray_btn: got %b want 110", BTN); end
    endtask

    task automatic test_en_drop();
        int bs, bf, bv;
        bit ok;
        set_rx(8'h00, 8'h01, 8'hFF, 8'h00, 8'h01);
        bs = n_st; bf = n_fall; bv = n_valid;
        wait_for(3, bs + 2, 200, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL endrop_timeout_start: byte 2 not started within 200 cycles"); end
        EN = 1'b0;
        wait_for(0, bv + 1, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL endrop_timeout_valid: no VALID within 100 cycles"); end
        vectors++; if (X !== 10'h100)  begin miscompares++; $display("FAIL endrop_x: got %h want 100", X); end
        vectors++; if (Y !== 10'h0FF)  begin miscompares++; $display("FAIL endrop_y: got %h want 0ff", Y); end
        vectors++; if (BTN !== 3'b001) begin miscompares++; $display("FAIL endrop_btn: got %b want 001", BTN); end
        repeat (300) step();
        vectors++; if (n_fall - bf !== 1) begin miscompares++; $display("FAIL endrop_no_more: got %0d transactions want 1", n_fall - bf); end
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL endrop_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_en_off();
        int bf, lows;
        bf = n_fall;
        lows = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (SS !== 1'b1) lows++;
        end
        vectors++; if (lows !== 0) begin miscompares++; $display("FAIL enoff_ss_low: got %0d low cycles want 0", lows); end
        vectors++; if (n_fall !== bf) begin miscompares++; $display("FAIL enoff_falls: got %0d want %0d", n_fall, bf); end
    endtask

    task automatic test_reset_mid();
        int bs, bv, r_cyc;
        bit ok;
        LED = 2'b11;
        set_rx(8'h11, 8'h01, 8'h22, 8'h02, 8'h07);
        bs = n_st;
        EN = 1'b1;
        wait_for(3, bs + 3, 200, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_timeout_start: byte 3 not started within 200 cycles"); end
        step();
        bv = n_valid;
        RST = 1'b0;
        #1;
        vectors++; if (SS !== 1'b1)    begin miscompares++; $display("FAIL rstmid_ss: got %b want 1", SS); end
        vectors++; if (BUSY !== 1'b0)  begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", BUSY); end
        vectors++; if (VALID !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b want 0", VALID); end
        vectors++; if (X !== 10'h000)  begin miscompares++; $display("FAIL rstmid_x: got %h want 000", X); end
        vectors++; if (Y !== 10'h000)  begin miscompares++; $display("FAIL rstmid_y: got %h want 000", Y); end
        vectors++; if (BTN !== 3'b000) begin miscompares++; $display("FAIL rstmid_btn: got %b want 000", BTN); end
        step(); step();
        set_rx(8'h55, 8'h01, 8'h66, 8'h03, 8'h03);
        bs = n_st;
        RST = 1'b1;
        r_cyc = cyc - 1;
        wait_for(0, bv + 1, 250, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_timeout_valid: no VALID within 250 cycles"); end
        vectors++; if (v_cyc[bv] - r_cyc !== 146) begin miscompares++; $display("FAIL rstmid_valid_time: got %0d want 146", v_cyc[bv] - r_cyc); end
        vectors++; if (n_st - bs !== 5) begin miscompares++; $display("FAIL rstmid_starts: got %0d want 5", n_st - bs); end
        vectors++; if (st_txd[bs] !== 8'h83) begin miscompares++; $display("FAIL rstmid_txd0: got %h want 83", st_txd[bs]); end
        vectors++; if (X !== 10'h155)  begin miscompares++; $display("FAIL rstmid_x2: got %h want 155", X); end
        vectors++; if (Y !== 10'h366)  begin miscompares++; $display("FAIL rstmid_y2: got %h want 366", Y); end
        vectors++; if (BTN !== 3'b011) begin miscompares++; $display("FAIL rstmid_btn2: got %b want 011", BTN); end
        vectors++; if (ss_bad !== 0) begin miscompares++; $display("FAIL rstmid_ss_vs_busy: got %0d want 0", ss_bad); end
    endtask

    initial begin
        set_rx(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        test_reset();
        test_normal();
        test_led_change();
        test_stray_done();
        test_en_drop();
        test_en_off();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
